// File: rtl/algo_nr_rderr_log_wrap.sv
// rtl/algo_nr_rderr_log_wrap.sv - read-port ECC error masking, counting and address logging
module algo_nr_rderr_log_wrap #(
  parameter int NUMRDPT  = 2,
  parameter int BITRDPT  = 1,
  parameter int BITPADR  = 17,
  parameter int FIFODPTH = 8,
  parameter int BITFIFO  = 3,
  parameter int CNTWDTH  = 16,
  parameter bit FLOPOUT  = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUMRDPT-1:0]           rd_vld_in,
  input  logic [NUMRDPT-1:0]           rd_serr_in,
  input  logic [NUMRDPT-1:0]           rd_derr_in,
  input  logic [NUMRDPT*BITPADR-1:0]   rd_padr_in,
  output logic [NUMRDPT-1:0]           rd_vld,
  output logic [NUMRDPT-1:0]           rd_serr,
  output logic [NUMRDPT-1:0]           rd_derr,
  output logic [NUMRDPT*BITPADR-1:0]   rd_padr,
  output logic                         log_vld,
  input  logic                         log_pop,
  output logic [BITPADR-1:0]           log_padr,
  output logic                         log_derr,
  output logic [BITRDPT-1:0]           log_port,
  output logic                         log_ovfl,
  output logic [CNTWDTH-1:0]           serr_cnt,
  output logic [CNTWDTH-1:0]           derr_cnt,
  input  logic                         cnt_clr
);

  localparam int ENTW = BITPADR + 1 + BITRDPT;

  logic [NUMRDPT-1:0] padr_msb;
  logic [NUMRDPT-1:0] serr_m;
  logic [NUMRDPT-1:0] derr_m;
  logic [NUMRDPT-1:0] err_any;
  logic [BITRDPT:0]   serr_pop;
  logic [BITRDPT:0]   derr_pop;
  logic [CNTWDTH:0]   serr_sum;
  logic [CNTWDTH:0]   derr_sum;
  logic [CNTWDTH-1:0] serr_nxt;
  logic [CNTWDTH-1:0] derr_nxt;

  logic               multi_err;
  logic               push_req;
  logic               push_ok;
  logic               pop_ok;
  logic               ovfl_set;
  logic [BITRDPT-1:0] cand_port;
  logic [BITPADR-1:0] cand_padr;
  logic               cand_derr;

  logic [BITFIFO:0]   wr_ptr;
  logic [BITFIFO:0]   rd_ptr;
  logic               fifo_empty;
  logic               fifo_full;
  logic [ENTW-1:0]    mem [FIFODPTH];

  function automatic logic [BITRDPT:0] popcnt(input logic [NUMRDPT-1:0] v);
    logic [BITRDPT:0] c;
    c = '0;
    for (int i = 0; i < NUMRDPT; i++) begin
      c = c + {{BITRDPT{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Per-port masking: cache-region reads never report errors, derr dominates serr
  always_comb begin
    padr_msb = '0;
    serr_m   = '0;
    derr_m   = '0;
    for (int p = 0; p < NUMRDPT; p++) begin
      padr_msb[p] = rd_padr_in[p*BITPADR + BITPADR - 1];
      derr_m[p]   = rd_vld_in[p] & ~padr_msb[p] & rd_derr_in[p];
      serr_m[p]   = rd_vld_in[p] & ~padr_msb[p] & rd_serr_in[p] & ~rd_derr_in[p];
    end
  end

  generate
    if (FLOPOUT) begin : g_flop
      // Registered read outputs, one cycle behind the inputs
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_vld  <= '0;
          rd_serr <= '0;
          rd_derr <= '0;
          rd_padr <= '0;
        end else begin
          rd_vld  <= rd_vld_in;
          rd_serr <= serr_m;
          rd_derr <= derr_m;
          rd_padr <= rd_padr_in;
        end
      end
    end else begin : g_comb
      assign rd_vld  = rd_vld_in;
      assign rd_serr = serr_m;
      assign rd_derr = derr_m;
      assign rd_padr = rd_padr_in;
    end
  endgenerate

  // Saturating counter next values; a clear zeroes the base before this cycle's errors are added
  always_comb begin
    serr_pop = popcnt(serr_m);
    derr_pop = popcnt(derr_m);
    serr_sum = {1'b0, (cnt_clr ? {CNTWDTH{1'b0}} : serr_cnt)} + {{(CNTWDTH-BITRDPT){1'b0}}, serr_pop};
    derr_sum = {1'b0, (cnt_clr ? {CNTWDTH{1'b0}} : derr_cnt)} + {{(CNTWDTH-BITRDPT){1'b0}}, derr_pop};
    serr_nxt = serr_sum[CNTWDTH] ? {CNTWDTH{1'b1}} : serr_sum[CNTWDTH-1:0];
    derr_nxt = derr_sum[CNTWDTH] ? {CNTWDTH{1'b1}} : derr_sum[CNTWDTH-1:0];
  end

  // Error counters
  always_ff @(posedge clk) begin
    if (rst) begin
      serr_cnt <= '0;
      derr_cnt <= '0;
    end else begin
      serr_cnt <= serr_nxt;
      derr_cnt <= derr_nxt;
    end
  end

  // Pick the log candidate: lowest-index derr port, else lowest-index serr port
  always_comb begin
    cand_derr = |derr_m;
    cand_port = '0;
    cand_padr = '0;
    for (int i = NUMRDPT - 1; i >= 0; i--) begin
      if (derr_m[i] || (!cand_derr && serr_m[i])) begin
        cand_port = BITRDPT'(i);
        cand_padr = rd_padr_in[i*BITPADR +: BITPADR];
      end
    end
  end

  // Push/pop qualification and overflow detection
  always_comb begin
    err_any    = serr_m | derr_m;
    multi_err  = |(err_any & (err_any - NUMRDPT'(1)));
    push_req   = |err_any;
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[BITFIFO] != rd_ptr[BITFIFO]) &&
                 (wr_ptr[BITFIFO-1:0] == rd_ptr[BITFIFO-1:0]);
    pop_ok     = log_pop & ~fifo_empty;
    push_ok    = push_req & (~fifo_full | pop_ok);
    ovfl_set   = (push_req & ~push_ok) | multi_err;
  end

  // Log FIFO storage and pointers; the extra pointer bit separates full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFODPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr[BITFIFO-1:0]] <= {cand_padr, cand_derr, cand_port};
        wr_ptr <= wr_ptr + (BITFIFO+1)'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + (BITFIFO+1)'(1);
      end
    end
  end

  assign log_vld = ~fifo_empty;
  assign {log_padr, log_derr, log_port} = mem[rd_ptr[BITFIFO-1:0]];

  // Sticky overflow flag; a new overflow wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      log_ovfl <= 1'b0;
    end else if (ovfl_set) begin
      log_ovfl <= 1'b1;
    end else if (cnt_clr) begin
      log_ovfl <= 1'b0;
    end
  end

endmodule
